// File: rtl/twitchcore_pkg.sv
// Shared types and constants for the twitchcore memory subsystem.
package twitchcore_pkg;

    localparam int WORD_W         = 32;
    localparam int DEFAULT_MEM_AW = 14;

    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} mem_owner_t;

    // A byte address is in range when every bit above the RAM word index is zero.
    function automatic logic addr_in_range(input logic [WORD_W-1:0] addr, input int aw);
        return (addr >> (aw + 2)) == '0;
    endfunction

endpackage

// File: rtl/twitchcore_mem_arbiter.sv
// Shares one single-port word RAM between instruction fetch and load/store,
// data-first with aging so fetch cannot starve; flags out-of-range accesses.
module twitchcore_mem_arbiter
    import twitchcore_pkg::*;
#(
    parameter int MEM_AW   = DEFAULT_MEM_AW,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [WORD_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [WORD_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [WORD_W-1:0] d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              fault
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    logic              i_ok;
    logic              d_ok;
    logic [3:0]        wait_cnt;
    mem_owner_t        owner_q;
    mem_owner_t        owner_d;
    logic              zero_q;
    logic              zero_d;
    logic              fault_q;
    logic [WORD_W-1:0] i_hold;
    logic [WORD_W-1:0] d_hold;
    logic [WORD_W-1:0] resp;

    assign i_ok = addr_in_range(i_addr, MEM_AW);
    assign d_ok = addr_in_range(d_addr, MEM_AW);

    // Winner selection plus the RAM command for the winning port; reset blocks all grants.
    always_comb begin
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        owner_d   = OWN_NONE;
        zero_d    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 4'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (i_req && (!d_req || wait_cnt == MAX_CNT)) begin
                i_gnt    = 1'b1;
                owner_d  = OWN_I;
                zero_d   = !i_ok;
                mem_en   = i_ok;
                mem_addr = i_addr[MEM_AW+1:2];
            end else if (d_req) begin
                d_gnt    = 1'b1;
                owner_d  = OWN_D;
                zero_d   = d_we || !d_ok;
                mem_en   = d_ok;
                mem_addr = d_addr[MEM_AW+1:2];
                if (d_we && d_ok) begin
                    mem_we    = d_be;
                    mem_wdata = d_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q  <= OWN_NONE;
            zero_q   <= 1'b0;
            wait_cnt <= 4'd0;
            fault_q  <= 1'b0;
            i_hold   <= '0;
            d_hold   <= '0;
        end else begin
            owner_q <= owner_d;
            zero_q  <= zero_d;
            fault_q <= fault_q | (i_gnt & !i_ok) | (d_gnt & !d_ok);
            if (i_req && !i_gnt)
                wait_cnt <= (wait_cnt == MAX_CNT) ? wait_cnt : wait_cnt + 4'd1;
            else
                wait_cnt <= 4'd0;
            if (owner_q == OWN_I)
                i_hold <= i_rdata;
            if (owner_q == OWN_D)
                d_hold <= d_rdata;
        end
    end

    // Stores and out-of-range accesses answer with zero instead of RAM data.
    assign resp     = zero_q ? '0 : mem_rdata;
    assign i_rvalid = (owner_q == OWN_I);
    assign d_rvalid = (owner_q == OWN_D);
    assign i_rdata  = i_rvalid ? resp : i_hold;
    assign d_rdata  = d_rvalid ? resp : d_hold;
    assign fault    = fault_q;

endmodule
